// File: rtl/bo_datapath_if.sv
// Control/data bundle between the polynomial controller, bo_datapath and the result consumer.
interface bo_datapath_if #(parameter int unsigned N = 8);
  logic [N-1:0] x_in;
  logic [0:1]   m0;
  logic [0:1]   m1;
  logic [0:1]   m2;
  logic         lx;
  logic         ls;
  logic         lh;
  logic         h;
  logic         done;
  logic         result_ack;
  logic [N-1:0] result;
  logic         result_valid;
  logic         ovf;

  modport master (
    output x_in, m0, m1, m2, lx, ls, lh, h, done, result_ack,
    input  result, result_valid, ovf
  );

  modport slave (
    input  x_in, m0, m1, m2, lx, ls, lh, h, done, result_ack,
    output result, result_valid, ovf
  );
endinterface

// File: rtl/bo_datapath.sv
// X/S/H datapath with add/multiply ALU, sticky overflow and a captured-result handshake.
// Optional macro BO_SAT_EN: write-bus code 00 saturates to all ones instead of wrapping.
module bo_datapath #(
  parameter int unsigned N = 8
) (
  input logic          clk,
  input logic          rst,
  bo_datapath_if.slave bus
);
  localparam int unsigned W2 = 2 * N;

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t       state, state_nxt;
  logic         capture_c;
  logic [N-1:0] x_q, s_q, h_q;
  logic [N-1:0] op_a, op_b, wbus;
  logic [W2-1:0] alu;
  logic [1:0]   a_code, b_code, w_code;
  logic         big, ovf_set, lx_q, lx_rise;
  logic [N-1:0] result_q;
  logic         valid_q, ovf_q;

  assign a_code  = {bus.m0[0], bus.m0[1]};
  assign b_code  = {bus.m1[0], bus.m1[1]};
  assign w_code  = {bus.m2[0], bus.m2[1]};
  assign lx_rise = bus.lx & ~lx_q;

  // Operand selection, ALU and write-bus mux; all from pre-edge register values
  always_comb begin
    op_a = '0;
    op_b = '0;
    wbus = '0;
    unique case (a_code)
      2'b00:   op_a = x_q;
      2'b01:   op_a = s_q;
      2'b10:   op_a = h_q;
      default: op_a = N'(1);
    endcase
    unique case (b_code)
      2'b00:   op_b = x_q;
      2'b01:   op_b = s_q;
      2'b10:   op_b = h_q;
      default: op_b = '0;
    endcase
    alu = bus.h ? (W2'(op_a) * W2'(op_b)) : (W2'(op_a) + W2'(op_b));
    big = |alu[W2-1:N];
    unique case (w_code)
`ifdef BO_SAT_EN
      2'b00:   wbus = big ? '1 : alu[N-1:0];
`else
      2'b00:   wbus = alu[N-1:0];
`endif
      2'b01:   wbus = x_q;
      2'b10:   wbus = '0;
      default: wbus = N'(1);
    endcase
    ovf_set = big & (w_code == 2'b00) & (bus.ls | bus.lh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      s_q  <= '0;
      h_q  <= '0;
      lx_q <= 1'b0;
    end else begin
      lx_q <= bus.lx;
      if (bus.lx) x_q <= bus.x_in;
      if (bus.ls) s_q <= wbus;
      if (bus.lh) h_q <= wbus;
    end
  end

  // Completion detector: one capture per done pulse, however long it is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.done) begin
          state_nxt = CAPTURE;
          capture_c = 1'b1;
        end
      end
      CAPTURE: begin
        if (!bus.done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result handshake and sticky overflow; a new job start clears both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (capture_c) begin
        result_q <= s_q;
        valid_q  <= 1'b1;
      end else if (lx_rise || bus.result_ack) begin
        valid_q  <= 1'b0;
      end
      if (lx_rise)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.ovf          = ovf_q;
endmodule

// File: doc/bo_datapath.md
# bo_datapath

Operational block (datapath) driven directly by the 4-state-bit control FSM of the polynomial/accumulate unit. It consumes the controller's mux selects (`m0`, `m1`, `m2`), load enables (`lx`, `ls`, `lh`), operation select (`h`) and `done`. It holds the X, S and H registers, performs one add or multiply per cycle, and presents the final S value with a valid/ack handshake to the downstream consumer.

## Interface
- `N`, 8: data width of `x_in`, X, S, H and `result`.
- `clk`  in  1  system clock; all registers update on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x_in`  in  N  operand; must be held stable while `lx`=1.
- `m0`  in  [0:1]  ALU operand A select; code = {m0[0],m0[1]}.
- `m1`  in  [0:1]  ALU operand B select; code = {m1[0],m1[1]}.
- `m2`  in  [0:1]  write-bus select; code = {m2[0],m2[1]}.
- `lx`  in  1  load X.
- `ls`  in  1  load S.
- `lh`  in  1  load H.
- `h`  in  1  ALU op: 0 = add, 1 = multiply.
- `done`  in  1  controller completion flag.
- `result_ack`  in  1  downstream consumed `result`.
- `result`  out  N  registered copy of S at job end.
- `result_valid`  out  1  `result` holds an unconsumed value.
- `ovf`  out  1  sticky overflow for the current job.

## Operation
- Operand A: 00 → X, 01 → S, 10 → H, 11 → constant 1.
- Operand B: 00 → X, 01 → S, 10 → H, 11 → 0.
- ALU is combinational and computes at 2N bits: add = A+B; mul = A×B.
- Write bus: 00 → ALU low N bits (or the saturated value, see Configuration); 01 → X; 10 → 0; 11 → 1.
- Register loads:
  - `lx`: X ← `x_in`.
  - `ls`: S ← write bus.
  - `lh`: H ← write bus.
  - Loads are independent. Simultaneous `ls`/`lh` write the same bus value to both registers.
  - All reads use pre-edge values. Example: S ← S+H with `lh` also asserted gives H ← old S + old H.
- Overflow: `ovf` sets when the ALU's 2N-bit result ≥ 2^N, m2 code = 00 and (`ls`|`lh`).
- Job boundary: a job starts on a rising edge of `lx` (previous cycle 0, current cycle 1). At that edge:
  - `ovf` clears.
  - `result_valid` clears, regardless of `result_ack`.
  - Clear takes priority over an overflow set in the same cycle.
- Completion detector (two states):
  - IDLE → CAPTURE on `done` rising edge: `result` ← S as it stands on that edge; `result_valid` ← 1.
  - CAPTURE → IDLE when `done` falls.
  - A `done` level held for several cycles captures only once.
- Handshake:
  - `result_valid` clears on the first clock with `result_ack`=1.
  - `result_ack` while `result_valid`=0 is ignored.
  - A capture and an ack in the same cycle: capture wins, and `result_valid` stays 1.
- Reset: X, S, H, `result` = 0; `result_valid` = 0; `ovf` = 0; detector in IDLE; internal `lx`/`done` history = 0. Asserting reset mid-job aborts the job immediately. No partial result is presented.

## Timing
- Register writes become visible one cycle after the enable.
- Chained operations are back-to-back with no bubble.
- `result`/`result_valid` become valid one cycle after the first cycle with `done`=1.
- `ovf` asserts one cycle after the overflowing write.
- The ALU path (N×N multiply plus muxes) is single-cycle. No pipelining.
- Outputs are registered only. No combinational path from inputs to outputs.

## Configuration
- `BO_SAT_EN` defined:
  - When the 2N-bit ALU result ≥ 2^N, write-bus code 00 delivers 2^N−1 (all ones).
  - `ovf` behaves as specified above.
- `BO_SAT_EN` undefined:
  - Code 00 delivers the low N bits (wrap modulo 2^N).
  - `ovf` logic is identical.

## Test plan
- Reset check: assert `rst` mid-job with S=0x37 and `result_valid`=1 → all outputs 0 asynchronously, before the next clock edge.
- Add/mul flow (N=8, x_in=3):
  - `lx`; then `ls` with m2=11 gives S=1.
  - Then `lh` with m0=00, m1=01, h=1 gives H=3.
  - Then `ls` with m0=01, m1=10, h=0 gives S=4.
  - `done` → `result`=4, `result_valid`=1 one cycle later.
  - Ack → `result_valid`=0.
- Overflow: x_in=0x20; H ← X×X → `ovf`=1. H=0x00 without `BO_SAT_EN`; H=0xFF with it.
- Held `done`: `done`=1 for 5 cycles while S changes after the first cycle → `result` equals S at the first `done` edge; single capture.
- Capture/ack collision: `result_ack`=1 on the same edge as a new capture → `result_valid` stays 1 with the new value. A new `lx` rising edge → `result_valid`=0 and `ovf`=0.
